// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scanner.
//
// Contents:
//   GLYPH_*   7-bit active-low segment patterns, bit order abcdefg (bit 6 = a).
//   CODE_OFF  glyph code that lights no segment.
//   CODE_DASH glyph code that lights only segment g.
//   glyph()   maps a 5-bit glyph code to its segment pattern. Undefined codes map to OFF.
package seven_seg_pkg;

    localparam logic [6:0] GLYPH_ZERO     = 7'b0000001;
    localparam logic [6:0] GLYPH_ONE      = 7'b1001111;
    localparam logic [6:0] GLYPH_TWO      = 7'b0010010;
    localparam logic [6:0] GLYPH_THREE    = 7'b0000110;
    localparam logic [6:0] GLYPH_FOUR     = 7'b1001100;
    localparam logic [6:0] GLYPH_FIVE     = 7'b0100100;
    localparam logic [6:0] GLYPH_SIX      = 7'b0100000;
    localparam logic [6:0] GLYPH_SEVEN    = 7'b0001111;
    localparam logic [6:0] GLYPH_EIGHT    = 7'b0000000;
    localparam logic [6:0] GLYPH_NINE     = 7'b0000100;
    localparam logic [6:0] GLYPH_TEN      = 7'b0001000;
    localparam logic [6:0] GLYPH_ELEVEN   = 7'b1100000;
    localparam logic [6:0] GLYPH_TWELVE   = 7'b0110001;
    localparam logic [6:0] GLYPH_THIRTEEN = 7'b1000010;
    localparam logic [6:0] GLYPH_FOURTEEN = 7'b0110000;
    localparam logic [6:0] GLYPH_FIFTEEN  = 7'b0111000;
    localparam logic [6:0] GLYPH_OFF      = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH     = 7'b1111110;

    localparam logic [4:0] CODE_OFF  = 5'd16;
    localparam logic [4:0] CODE_DASH = 5'd17;

    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] pattern;
        case (code)
            5'd0:      pattern = GLYPH_ZERO;
            5'd1:      pattern = GLYPH_ONE;
            5'd2:      pattern = GLYPH_TWO;
            5'd3:      pattern = GLYPH_THREE;
            5'd4:      pattern = GLYPH_FOUR;
            5'd5:      pattern = GLYPH_FIVE;
            5'd6:      pattern = GLYPH_SIX;
            5'd7:      pattern = GLYPH_SEVEN;
            5'd8:      pattern = GLYPH_EIGHT;
            5'd9:      pattern = GLYPH_NINE;
            5'd10:     pattern = GLYPH_TEN;
            5'd11:     pattern = GLYPH_ELEVEN;
            5'd12:     pattern = GLYPH_TWELVE;
            5'd13:     pattern = GLYPH_THIRTEEN;
            5'd14:     pattern = GLYPH_FOURTEEN;
            5'd15:     pattern = GLYPH_FIFTEEN;
            CODE_DASH: pattern = GLYPH_DASH;
            default:   pattern = GLYPH_OFF;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder: a per-digit code goes in and an active-low abcdefg pattern comes out.
//
// Ports:
//   code_i    [CODE_W-1:0]  glyph code
//   pattern_o [6:0]         active-low segment pattern (bit 6 = a, bit 0 = g)
//
// When CODE_W is wider than 5 bits, any code with a set bit above bit 4 decodes to OFF.
module seg_glyph_decode
    import seven_seg_pkg::*;
#(
    parameter int CODE_W = 5
) (
    input  logic [CODE_W-1:0] code_i,
    output logic [6:0]        pattern_o
);

    if (CODE_W > 5) begin : g_wide
        assign pattern_o = (|code_i[CODE_W-1:5]) ? GLYPH_OFF : glyph(code_i[4:0]);
    end else begin : g_narrow
        assign pattern_o = glyph(5'(code_i));
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   en           display enable. When en is 0, all anodes are off but scanning keeps running.
//   digits_in    packed glyph codes; digit i = digits_in[i*CODE_W +: CODE_W]
//   an           active-low anode selects; an[i] drives digit i
//   seg          active-low segments, seg[6] = a ... seg[0] = g
//   frame_start  one-cycle pulse when the slot of digit 0 begins
//   dp_in, dp    only present when SEVEN_SEG_SCANNER_DP_EN is defined.
//                dp_in holds active-high per-digit decimal-point requests.
//                dp is the active-low decimal-point output.
//
// Each digit slot lasts REFRESH_DIV cycles. The first BLANK_CYCLES cycles of a slot keep
// all anodes off (BLANK). This prevents ghosting when the anode and segment lines switch.
// For the rest of the slot (SHOW), the current digit is driven.
//
// The inputs are captured into a shadow register once per frame, at slot 0 of digit 0.
// Because of this, a whole frame always shows a single consistent value.
//
// All outputs are registered. They follow slot_cnt, digit and state with one cycle of latency.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CODE_W       = 5,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_DIGITS*CODE_W-1:0] digits_in,
`ifdef SEVEN_SEG_SCANNER_DP_EN
    input  logic [NUM_DIGITS-1:0]        dp_in,
`endif
    output logic [NUM_DIGITS-1:0]        an,
    output logic [6:0]                   seg,
    output logic                         frame_start
`ifdef SEVEN_SEG_SCANNER_DP_EN
    ,
    output logic                         dp
`endif
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    // The state register is updated one cycle ahead, so that state_q == SHOW
    // exactly when slot_cnt_q == BLANK_CYCLES.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [NUM_DIGITS*CODE_W-1:0] SHADOW_RESET = {NUM_DIGITS{CODE_W'(CODE_OFF)}};

    logic [CNT_W-1:0]             slot_cnt_q, slot_cnt_d;
    logic [DIG_W-1:0]             digit_q, digit_d;
    logic [0:0]                   state_q, state_d;
    logic [NUM_DIGITS*CODE_W-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]        an_q, an_d;
    logic [6:0]                   seg_q, seg_d;
    logic                         frame_start_q, frame_start_d;

    logic              slot_wrap;
    logic              frame_pos;
    logic              show_on;
    logic [CODE_W-1:0] cur_code;
    logic [6:0]        cur_glyph;

    assign slot_wrap = (slot_cnt_q == CNT_LAST);
    assign frame_pos = (slot_cnt_q == '0) && (digit_q == '0);
    assign show_on   = (state_q == ST_SHOW) && en;
    assign cur_code  = shadow_q[digit_q*CODE_W +: CODE_W];

    seg_glyph_decode #(
        .CODE_W (CODE_W)
    ) u_decode (
        .code_i    (cur_code),
        .pattern_o (cur_glyph)
    );

    always_comb begin
        slot_cnt_d    = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        digit_d       = digit_q;
        if (slot_wrap) begin
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
        end

        state_d = state_q;
        case (state_q)
            ST_BLANK: if (slot_cnt_q == BLANK_LAST) state_d = ST_SHOW;
            ST_SHOW:  if (slot_wrap)                state_d = ST_BLANK;
            default:                                state_d = ST_BLANK;
        endcase

        shadow_d      = frame_pos ? digits_in : shadow_q;
        frame_start_d = frame_pos;

        // The anode and the segments both come from the same digit_q in the same cycle,
        // so one digit's anode can never be paired with another digit's segments.
        an_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (show_on && (digit_q == DIG_W'(i))) an_d[i] = 1'b0;
        end
        seg_d = show_on ? cur_glyph : GLYPH_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q    <= '0;
            digit_q       <= '0;
            state_q       <= ST_BLANK;
            shadow_q      <= SHADOW_RESET;
            an_q          <= '1;
            seg_q         <= GLYPH_OFF;
            frame_start_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_q       <= digit_d;
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_start = frame_start_q;

`ifdef SEVEN_SEG_SCANNER_DP_EN
    logic [NUM_DIGITS-1:0] dp_shadow_q, dp_shadow_d;
    logic                  dp_q, dp_d;

    always_comb begin
        dp_shadow_d = frame_pos ? dp_in : dp_shadow_q;
        dp_d        = show_on ? ~dp_shadow_q[digit_q] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_shadow_q <= '0;
            dp_q        <= 1'b1;
        end else begin
            dp_shadow_q <= dp_shadow_d;
            dp_q        <= dp_d;
        end
    end

    assign dp = dp_q;
`endif

endmodule
